// File: rtl/bridge_rx_if.sv
// Request-path bundle between the UART byte stream, bridge_rx and the bus core.
// The slave side is bridge_rx; the master side feeds bytes and consumes requests.
interface bridge_rx_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            data_i;
  logic                  valid_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rw_o;
  logic                  valid_o;

  modport master (
    output data_i, valid_i,
    input  addr_o, data_o, rw_o, valid_o
  );

  modport slave (
    input  data_i, valid_i,
    output addr_o, data_o, rw_o, valid_o
  );
endinterface

// File: rtl/bridge_rx.sv
// ASCII hex command parser: "R<addr>\r" / "W<addr><data>\r" -> one-cycle bus request, latency 1.
// No backpressure: one byte per valid_i cycle. BRIDGE_RX_LOWERCASE_EN also accepts a-f and r/w.
module bridge_rx #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  bridge_rx_if.slave  bus
);

  localparam int ADIG = ADDR_WIDTH / 4;
  localparam int DDIG = DATA_WIDTH / 4;
  localparam int MAXD = (ADIG > DDIG) ? ADIG : DDIG;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_EOL
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rwo_q, rwo_d;
  logic                  vld_q, vld_d;

  logic       is_hex, is_rd, is_wr, is_term;
  logic [3:0] nib;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (bus.data_i >= 8'h30 && bus.data_i <= 8'h39) begin
      is_hex = 1'b1;
      nib    = bus.data_i[3:0];
    end else if (bus.data_i >= 8'h41 && bus.data_i <= 8'h46) begin
      is_hex = 1'b1;
      nib    = bus.data_i[3:0] + 4'd9;
    end
`ifdef BRIDGE_RX_LOWERCASE_EN
    else if (bus.data_i >= 8'h61 && bus.data_i <= 8'h66) begin
      is_hex = 1'b1;
      nib    = bus.data_i[3:0] + 4'd9;
    end
    is_rd = (bus.data_i == 8'h52) || (bus.data_i == 8'h72);
    is_wr = (bus.data_i == 8'h57) || (bus.data_i == 8'h77);
`else
    is_rd = (bus.data_i == 8'h52);
    is_wr = (bus.data_i == 8'h57);
`endif
    is_term = (bus.data_i == 8'h0D) || (bus.data_i == 8'h0A);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rwo_d     = rwo_q;
    vld_d     = 1'b0;

    if (bus.valid_i) begin
      // A command byte restarts parsing from any state.
      if (is_rd || is_wr) begin
        state_d   = S_ADDR;
        rw_d      = is_wr;
        cnt_d     = '0;
        addr_sh_d = '0;
        data_sh_d = '0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (is_hex) begin
              addr_sh_d = (addr_sh_q << 4) | ADDR_WIDTH'(nib);
              if (cnt_q == CW'(ADIG - 1)) begin
                cnt_d   = '0;
                state_d = rw_q ? S_DATA : S_EOL;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          S_DATA: begin
            if (is_hex) begin
              data_sh_d = (data_sh_q << 4) | DATA_WIDTH'(nib);
              if (cnt_q == CW'(DDIG - 1)) begin
                cnt_d   = '0;
                state_d = S_EOL;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          S_EOL: begin
            if (is_term) begin
              vld_d  = 1'b1;
              addr_d = addr_sh_q;
              data_d = rw_q ? data_sh_q : '0;
              rwo_d  = rw_q;
            end
            state_d = S_IDLE;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rwo_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rwo_q     <= rwo_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.addr_o  = addr_q;
  assign bus.data_o  = data_q;
  assign bus.rw_o    = rwo_q;
  assign bus.valid_o = vld_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Directed bench for bridge_rx: expected requests are queued as bytes are sent and
// matched against each valid_o pulse; build with +define+BRIDGE_RX_LOWERCASE_EN to match the RTL build.
module tb_bridge_rx;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
  } req_t;

  logic clk;
  logic rst;

  bridge_rx_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  bridge_rx #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks     = 0;
  int passed     = 0;
  int pulses     = 0;
  int exp_pulses = 0;
  req_t sb[$];
  logic [15:0] last_addr = 16'h0;
  logic [15:0] last_data = 16'h0;
  logic        last_rw   = 1'b0;
  logic        prev_vld  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      req_t r;
      pulses++;
      chk("no_double_pulse", {31'd0, prev_vld}, 32'd0);
      chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("addr_o", {16'd0, bus.addr_o}, {16'd0, r.addr});
        chk("data_o", {16'd0, bus.data_o}, {16'd0, r.data});
        chk("rw_o", {31'd0, bus.rw_o}, {31'd0, r.rw});
      end
    end
    prev_vld = (bus.valid_o === 1'b1);
  end

  task automatic expect_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
    req_t r;
    r.addr = a;
    r.data = rw ? d : 16'h0;
    r.rw   = rw;
    sb.push_back(r);
    exp_pulses++;
    last_addr = r.addr;
    last_data = r.data;
    last_rw   = rw;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.data_i  = s[i];
      bus.valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_pulse_count"}, pulses, exp_pulses);
    chk({tag, "_queue_drained"}, sb.size(), 0);
    chk({tag, "_hold_addr"}, {16'd0, bus.addr_o}, {16'd0, last_addr});
    chk({tag, "_hold_data"}, {16'd0, bus.data_o}, {16'd0, last_data});
    chk({tag, "_hold_rw"}, {31'd0, bus.rw_o}, {31'd0, last_rw});
  endtask

  initial begin
    rst         = 1'b1;
    bus.data_i  = 8'h00;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", {16'd0, bus.addr_o}, 32'd0);
    chk("rst_data", {16'd0, bus.data_o}, 32'd0);
    chk("rst_rw", {31'd0, bus.rw_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read, then a back-to-back CRLF write whose LF must not re-trigger.
    expect_req(16'h1234, 16'h0, 1'b0);
    send_str("R1234\r");
    settle("read");
    expect_req(16'h89AB, 16'hCDEF, 1'b1);
    send_str("W89ABCDEF\r\n");
    settle("write_crlf");
    expect_req(16'hA5A5, 16'h0, 1'b0);
    expect_req(16'h0F0F, 16'h1357, 1'b1);
    send_str("RA5A5\rW0F0F1357\n");
    settle("back_to_back");

    // Bad digit drops the message; outputs keep the previous request.
    send_str("R12G4\r");
    settle("bad_digit");
    expect_req(16'h0042, 16'h0, 1'b0);
    send_str("R0042\n");
    settle("recover");

    // Mid-message restart and premature terminator.
    expect_req(16'h5678, 16'h0, 1'b0);
    send_str("W12R5678\r");
    settle("restart");
    send_str("R12\r");
    settle("premature");
    send_str("W1234AB\r");
    settle("premature_write");

    // Reset mid-message discards the partial write.
    send_str("W0001");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_addr = 16'h0;
    last_data = 16'h0;
    last_rw   = 1'b0;
    send_str("00FF\r");
    settle("reset_mid");
    expect_req(16'h00FF, 16'h0, 1'b0);
    send_str("R00FF\r");
    settle("after_reset");

`ifdef BRIDGE_RX_LOWERCASE_EN
    expect_req(16'hABCD, 16'h0001, 1'b1);
`endif
    send_str("Wabcd0001\r");
    settle("lowercase");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
